branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning in-flight prediction queue depth (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pred_valid, input, 1, a new prediction is issued this cycle.
REQ-006 SHALL have port pred_taken, input, 1, the predicted direction, qualified by pred_valid.
REQ-007 SHALL have port resolve_valid, input, 1, execute stage reports the actual outcome of the oldest branch.
REQ-008 SHALL have port resolve_taken, input, 1, the actual direction, qualified by resolve_valid.
REQ-009 SHALL have port result, output, 1, a one-cycle pulse telling the predictor an outcome is available.
REQ-010 SHALL have port taken, output, 1, the actual direction accompanying result.
REQ-011 SHALL have port mispredict, output, 1, a one-cycle pulse asserted with result when prediction != outcome.
REQ-012 SHALL have port full, output, 1, asserted when the queue holds DEPTH entries.
REQ-013 SHALL have port empty, output, 1, asserted when the queue holds 0 entries.
REQ-014 SHALL have port pending, output, $clog2(DEPTH)+1, current queue occupancy.
REQ-015 SHALL have port branch_count, output, CNT_W, number of resolved branches.
REQ-016 SHALL have port mispredict_count, output, CNT_W, number of mispredicted branches.
REQ-017 SHALL have port overflow_err, output, 1, sticky flag for a dropped push.
REQ-018 SHALL have port underflow_err, output, 1, sticky flag for a resolve received while empty.

Function
REQ-019 SHALL push pred_taken into a FIFO when pred_valid=1 and either not full or a valid pop occurs in the same cycle.
REQ-020 SHALL pop the oldest entry when resolve_valid=1 and not empty.
REQ-021 SHALL register outputs so that result, taken and mispredict appear exactly one cycle after the popping edge, each for one cycle.
REQ-022 SHALL set mispredict = (popped entry != resolve_taken).
REQ-023 SHALL, on a mispredicting pop, discard all remaining entries and any push in the same cycle, leaving pending=0 next cycle.
REQ-024 SHALL, on pred_valid while full without a pop, drop the push, keep the contents unchanged and set overflow_err.
REQ-025 SHALL, on resolve_valid while empty, generate no result pulse, change no counters and set underflow_err; a push in the same cycle is still accepted.
REQ-026 SHALL, on a simultaneous push and correct pop, keep pending unchanged and preserve FIFO order.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL increment branch_count on every pop and mispredict_count on every mispredicting pop; both SHALL saturate at 2^CNT_W-1.
REQ-029 SHALL derive full and empty from a registered occupancy count, not from a pointer compare alone.

Reset
REQ-030 SHALL asynchronously force result=0, taken=0, mispredict=0, pending=0, empty=1, full=0, both counters=0 and both error flags=0 while rst_n=0.
REQ-031 SHALL discard all in-flight entries when reset is asserted mid-operation; the first result after release SHALL come only from a post-reset push.
REQ-032 SHALL clear sticky error flags only by reset.

Structure
REQ-033 SHALL take the default depth, default counter width and the saturation-max helper from a shared package bp_pkg.
REQ-034 SHALL implement the queue as one sub-module bp_fifo (push, pop, clear, data, occupancy); compare, counters and flags SHALL reside in branch_resolver.

Verification
REQ-035 SHALL test: push 1,0,1, then resolve 1,0,1 -> three result pulses with taken 1,0,1, mispredict never asserted, branch_count=3, mispredict_count=0, empty=1.
REQ-036 SHALL test: push 1,1,0, then resolve 0 -> mispredict pulse one cycle later, pending=0, mispredict_count=1; a following resolve sets underflow_err with no result pulse.
REQ-037 SHALL test, with DEPTH=4: 5 pushes without a pop -> full=1 after the 4th push, the 5th push is dropped, overflow_err=1, pending=4.
REQ-038 SHALL test, with the queue full: push and correct pop in the same cycle -> pending stays 4, overflow_err stays 0, order is preserved across the pointer wrap.
REQ-039 SHALL test: assert rst_n=0 asynchronously with 3 entries pending -> all outputs reach reset values immediately; after release, resolve produces no result and sets underflow_err.
REQ-040 SHALL test, with CNT_W=4: 20 mispredicting push/resolve pairs -> both counters saturate at 15.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch resolver slice:
//   BP_DEPTH_DEF  - default in-flight prediction queue depth
//   BP_CNT_W_DEF  - default statistics counter width
//   bp_result_t   - registered outcome payload returned to the predictor
//   sat_max()     - all-ones value for a counter of a given width (1..32)
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int unsigned BP_DEPTH_DEF = 4;
    localparam int unsigned BP_CNT_W_DEF = 16;

    // Outcome payload presented to the predictor one cycle after a pop.
    typedef struct packed {
        logic valid;
        logic taken;
        logic mispredict;
    } bp_result_t;

    // Saturation ceiling for a counter of width w; widths above 32 clamp.
    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return '1;
        end
        return (32'(1) << w) - 32'(1);
    endfunction

endpackage : bp_pkg

// File: rtl/branch_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_resolver_if
// Handshake bundle between the fetch/execute side and the branch resolver.
//   pred_valid / pred_taken       - new prediction issued this cycle
//   resolve_valid / resolve_taken - actual outcome of the oldest branch
//   result / taken / mispredict   - registered one-cycle outcome pulse
// master: predictor/execute side; slave: branch_resolver.
// ---------------------------------------------------------------------------
interface branch_resolver_if;

    logic pred_valid;
    logic pred_taken;
    logic resolve_valid;
    logic resolve_taken;
    logic result;
    logic taken;
    logic mispredict;

    modport master (
        output pred_valid,
        output pred_taken,
        output resolve_valid,
        output resolve_taken,
        input  result,
        input  taken,
        input  mispredict
    );

    modport slave (
        input  pred_valid,
        input  pred_taken,
        input  resolve_valid,
        input  resolve_taken,
        output result,
        output taken,
        output mispredict
    );

endinterface : branch_resolver_if

// File: rtl/bp_fifo.sv
// ---------------------------------------------------------------------------
// bp_fifo
// Single-bit prediction queue with a registered occupancy count.
//   clk, rst_n  - clock, async active-low reset
//   push_i      - write wdata_i at the tail (ignored when full unless popping)
//   pop_i       - advance the head (ignored when empty)
//   clear_i     - drop every entry; overrides push/pop in the same cycle
//   wdata_i     - predicted direction to enqueue
//   rdata_c     - combinational view of the oldest entry
//   count_o     - registered occupancy
//   full_o      - registered, occupancy == DEPTH
//   empty_o     - registered, occupancy == 0
// ---------------------------------------------------------------------------
module bp_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic                   wdata_i,
    output logic                   rdata_c,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok_c, pop_ok_c;

    // Legality is judged on the registered count, never on a pointer compare.
    assign pop_ok_c  = pop_i && (count_q != '0);
    assign push_ok_c = push_i && ((count_q != OCC_W'(DEPTH)) || pop_ok_c);

    // Next-state: DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok_c) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            unique case ({push_ok_c, pop_ok_c})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; flags are registered from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == OCC_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_c = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule : bp_fifo

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Tracks in-flight branch predictions, compares each against the resolved
// outcome and returns a registered result pulse to the predictor.
//   clk, rst_n        - clock, async active-low reset
//   bus (slave)       - prediction/resolve inputs, result/taken/mispredict out
//   full, empty       - queue occupancy flags
//   pending           - queue occupancy
//   branch_count      - saturating count of resolved branches
//   mispredict_count  - saturating count of mispredicted branches
//   overflow_err      - sticky: a push was dropped on a full queue
//   underflow_err     - sticky: a resolve arrived with the queue empty
// CNT_W is supported in the range 1..32.
// ---------------------------------------------------------------------------
module branch_resolver
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = BP_DEPTH_DEF,
    parameter int unsigned CNT_W = BP_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolver_if.slave       bus,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] pending,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       mispredict_count,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic                   head_c;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop_c, push_c, mis_c;

    bp_result_t       res_q, res_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // A mispredict flushes the queue, so the same-cycle push is discarded too.
    assign pop_c  = bus.resolve_valid && !fifo_empty;
    assign mis_c  = pop_c && (head_c != bus.resolve_taken);
    assign push_c = bus.pred_valid && (!fifo_full || pop_c) && !mis_c;

    bp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .clear_i (mis_c),
        .wdata_i (bus.pred_taken),
        .rdata_c (head_c),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state for result payload, statistics and sticky error flags.
    always_comb begin
        res_d            = '0;
        bcnt_d           = bcnt_q;
        mcnt_d           = mcnt_q;
        ovf_d            = ovf_q;
        udf_d            = udf_q;

        res_d.valid      = pop_c;
        res_d.taken      = pop_c && bus.resolve_taken;
        res_d.mispredict = mis_c;

        if (pop_c && (bcnt_q != CNT_MAX)) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end
        if (mis_c && (mcnt_q != CNT_MAX)) begin
            mcnt_d = mcnt_q + CNT_W'(1);
        end
        // A push alongside a pop on a full queue is legal, not an overflow.
        if (bus.pred_valid && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (bus.resolve_valid && fifo_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign bus.result       = res_q.valid;
    assign bus.taken        = res_q.taken;
    assign bus.mispredict   = res_q.mispredict;
    assign full             = fifo_full;
    assign empty            = fifo_empty;
    assign pending          = fifo_count;
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;
    assign overflow_err     = ovf_q;
    assign underflow_err    = udf_q;

endmodule : branch_resolver

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
// Directed bench: u_dut (DEPTH=4, CNT_W=16) for the queue behaviour and
// u_sat (DEPTH=4, CNT_W=4) for counter saturation.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_resolver_if bus_a ();
    branch_resolver_if bus_b ();

    logic        a_full, a_empty, a_ovf, a_udf;
    logic [2:0]  a_pend;
    logic [15:0] a_bcnt, a_mcnt;

    logic        b_full, b_empty, b_ovf, b_udf;
    logic [2:0]  b_pend;
    logic [3:0]  b_bcnt, b_mcnt;

    branch_resolver #(.DEPTH(4), .CNT_W(16)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus_a),
        .full             (a_full),
        .empty            (a_empty),
        .pending          (a_pend),
        .branch_count     (a_bcnt),
        .mispredict_count (a_mcnt),
        .overflow_err     (a_ovf),
        .underflow_err    (a_udf)
    );

    branch_resolver #(.DEPTH(4), .CNT_W(4)) u_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus_b),
        .full             (b_full),
        .empty            (b_empty),
        .pending          (b_pend),
        .branch_count     (b_bcnt),
        .mispredict_count (b_mcnt),
        .overflow_err     (b_ovf),
        .underflow_err    (b_udf)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock on bus_a: drive, take the edge, sample 1 time unit later.
    task automatic cyc_a(input logic pv, input logic pt, input logic rv, input logic rt);
        bus_a.pred_valid    = pv;
        bus_a.pred_taken    = pt;
        bus_a.resolve_valid = rv;
        bus_a.resolve_taken = rt;
        @(posedge clk);
        #1;
        bus_a.pred_valid    = 1'b0;
        bus_a.pred_taken    = 1'b0;
        bus_a.resolve_valid = 1'b0;
        bus_a.resolve_taken = 1'b0;
    endtask

    task automatic cyc_b(input logic pv, input logic pt, input logic rv, input logic rt);
        bus_b.pred_valid    = pv;
        bus_b.pred_taken    = pt;
        bus_b.resolve_valid = rv;
        bus_b.resolve_taken = rt;
        @(posedge clk);
        #1;
        bus_b.pred_valid    = 1'b0;
        bus_b.pred_taken    = 1'b0;
        bus_b.resolve_valid = 1'b0;
        bus_b.resolve_taken = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_result"}, 32'(bus_a.result), 32'd0);
        check({tag, "_taken"},  32'(bus_a.taken), 32'd0);
        check({tag, "_mispr"},  32'(bus_a.mispredict), 32'd0);
        check({tag, "_pend"},   32'(a_pend), 32'd0);
        check({tag, "_empty"},  32'(a_empty), 32'd1);
        check({tag, "_full"},   32'(a_full), 32'd0);
        check({tag, "_bcnt"},   32'(a_bcnt), 32'd0);
        check({tag, "_mcnt"},   32'(a_mcnt), 32'd0);
        check({tag, "_ovf"},    32'(a_ovf), 32'd0);
        check({tag, "_udf"},    32'(a_udf), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       q[$];
        logic       exp_t;
        logic [2:0] pat;

        bus_a.pred_valid = 1'b0; bus_a.pred_taken = 1'b0;
        bus_a.resolve_valid = 1'b0; bus_a.resolve_taken = 1'b0;
        bus_b.pred_valid = 1'b0; bus_b.pred_taken = 1'b0;
        bus_b.resolve_valid = 1'b0; bus_b.resolve_taken = 1'b0;

        // Reset values
        #12;
        check_reset_a("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // push 1,0,1 then resolve 1,0,1: all correct
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 0, 0, 0);
        cyc_a(1, 1, 0, 0);
        check("seq_pend3", 32'(a_pend), 32'd3);
        pat = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            cyc_a(0, 0, 1, pat[i]);
            check("seq_result", 32'(bus_a.result), 32'd1);
            check("seq_taken", 32'(bus_a.taken), 32'(pat[i]));
            check("seq_mispr", 32'(bus_a.mispredict), 32'd0);
        end
        check("seq_bcnt", 32'(a_bcnt), 32'd3);
        check("seq_mcnt", 32'(a_mcnt), 32'd0);
        check("seq_empty", 32'(a_empty), 32'd1);
        cyc_a(0, 0, 0, 0);
        check("seq_pulse_end", 32'(bus_a.result), 32'd0);

        // push 1,1,0 then resolve 0: head is 1, so mispredict and flush
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 0, 0, 0);
        cyc_a(0, 0, 1, 0);
        check("mis_result", 32'(bus_a.result), 32'd1);
        check("mis_pulse", 32'(bus_a.mispredict), 32'd1);
        check("mis_taken", 32'(bus_a.taken), 32'd0);
        check("mis_pend", 32'(a_pend), 32'd0);
        check("mis_mcnt", 32'(a_mcnt), 32'd1);
        check("mis_bcnt", 32'(a_bcnt), 32'd4);
        cyc_a(0, 0, 1, 0);
        check("udf_result", 32'(bus_a.result), 32'd0);
        check("udf_flag", 32'(a_udf), 32'd1);
        check("udf_bcnt", 32'(a_bcnt), 32'd4);

        // resolve while empty with a push: push still accepted
        cyc_a(1, 1, 1, 1);
        check("udf_push_pend", 32'(a_pend), 32'd1);
        check("udf_push_result", 32'(bus_a.result), 32'd0);
        // mispredict with a same-cycle push: push discarded
        cyc_a(1, 1, 1, 0);
        check("mis_push_pend", 32'(a_pend), 32'd0);
        check("mis_push_mcnt", 32'(a_mcnt), 32'd2);

        // five pushes into DEPTH=4
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 0, 0, 0);
        cyc_a(1, 0, 0, 0);
        check("fill3_full", 32'(a_full), 32'd0);
        cyc_a(1, 1, 0, 0);
        check("fill4_full", 32'(a_full), 32'd1);
        check("fill4_pend", 32'(a_pend), 32'd4);
        check("fill4_ovf", 32'(a_ovf), 32'd0);
        cyc_a(1, 0, 0, 0);
        check("fill5_ovf", 32'(a_ovf), 32'd1);
        check("fill5_pend", 32'(a_pend), 32'd4);
        check("fill5_full", 32'(a_full), 32'd1);
        // contents must be 1,0,0,1 with the dropped push absent
        pat = 3'b100;
        cyc_a(0, 0, 1, 1);
        check("ovf_head", 32'(bus_a.mispredict), 32'd0);
        cyc_a(0, 0, 1, 0);
        check("ovf_e1", 32'(bus_a.mispredict), 32'd0);
        cyc_a(0, 0, 1, 0);
        check("ovf_e2", 32'(bus_a.mispredict), 32'd0);
        cyc_a(0, 0, 1, 1);
        check("ovf_e3", 32'(bus_a.mispredict), 32'd0);
        check("ovf_sticky", 32'(a_ovf), 32'd1);

        // clear sticky flags with reset only
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("ovf_rst", 32'(a_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // full queue: push + correct pop keeps pending at 4, order across wrap
        q.delete();
        foreach (pat[i]) begin end
        cyc_a(1, 1, 0, 0); q.push_back(1'b1);
        cyc_a(1, 0, 0, 0); q.push_back(1'b0);
        cyc_a(1, 1, 0, 0); q.push_back(1'b1);
        cyc_a(1, 1, 0, 0); q.push_back(1'b1);
        check("wrap_full", 32'(a_full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            logic nv;
            nv    = (i % 3) == 1;
            exp_t = q.pop_front();
            q.push_back(nv);
            cyc_a(1, nv, 1, exp_t);
            check("wrap_result", 32'(bus_a.result), 32'd1);
            check("wrap_taken", 32'(bus_a.taken), 32'(exp_t));
            check("wrap_mispr", 32'(bus_a.mispredict), 32'd0);
            check("wrap_pend", 32'(a_pend), 32'd4);
            check("wrap_ovf", 32'(a_ovf), 32'd0);
        end
        while (q.size() > 0) begin
            exp_t = q.pop_front();
            cyc_a(0, 0, 1, exp_t);
            check("drain_taken", 32'(bus_a.taken), 32'(exp_t));
            check("drain_mispr", 32'(bus_a.mispredict), 32'd0);
        end
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_bcnt", 32'(a_bcnt), 32'd9);

        // async reset mid-operation with 3 entries pending and a live pulse
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 1, 0, 0);
        cyc_a(1, 1, 0, 0);
        cyc_a(0, 0, 1, 1);
        check("pre_rst_pend", 32'(a_pend), 32'd3);
        check("pre_rst_result", 32'(bus_a.result), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("arst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc_a(0, 0, 1, 1);
        check("post_rst_result", 32'(bus_a.result), 32'd0);
        check("post_rst_udf", 32'(a_udf), 32'd1);
        check("post_rst_bcnt", 32'(a_bcnt), 32'd0);
        cyc_a(1, 0, 0, 0);
        cyc_a(0, 0, 1, 0);
        check("post_rst_first", 32'(bus_a.result), 32'd1);
        check("post_rst_first_mis", 32'(bus_a.mispredict), 32'd0);

        // CNT_W=4: 20 mispredicting pairs saturate both counters at 15
        for (int i = 0; i < 20; i++) begin
            cyc_b(1, 1, 0, 0);
            cyc_b(0, 0, 1, 0);
            if (i == 13) begin
                check("sat_bcnt_14", 32'(b_bcnt), 32'd14);
            end
        end
        check("sat_bcnt", 32'(b_bcnt), 32'd15);
        check("sat_mcnt", 32'(b_mcnt), 32'd15);
        check("sat_mispr", 32'(bus_b.mispredict), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_branch_resolver
